// File: rtl/jump_regularizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jump_regularizer_pkg
// Description : Shared constants for the jump regularizer: the reset level of
//               the regularized output, the default debounce/hold timings and
//               a helper that sizes the internal counters.
// Revision    : 1.0 - initial release
// ============================================================================
package jump_regularizer_pkg;

    // Level every output and sample register takes while reset is asserted.
    localparam logic REG_RESET_LEVEL  = 1'b1;

    // Default timing: 5-clock debounce, 200-clock hold (2 us at 100 MHz).
    localparam int   DEFAULT_DEBOUNCE = 5;
    localparam int   DEFAULT_DELAY    = 200;
    localparam int   CLK_PERIOD_NS    = 10;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_regularizer_channel.sv
`default_nettype none
// ============================================================================
// Module      : jump_regularizer_channel
// Description : Single-bit debounce-plus-hold engine. The input is registered
//               once, a mismatch against the output must persist for
//               DEBOUNCE_TIME edges before the output toggles, and after
//               every toggle the output is frozen for DELAY edges.
// Ports       : i_clk     - system clock, rising edge
//               i_reset   - asynchronous reset, active low
//               i_signal  - raw switching request
//               o_signal  - regularized switching variable (registered)
//               o_inhibit - hold active (only with JUMP_REGULARIZER_STATUS_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module jump_regularizer_channel
    import jump_regularizer_pkg::*;
#(
    parameter int DEBOUNCE_TIME = DEFAULT_DEBOUNCE,
    parameter int DELAY         = DEFAULT_DELAY
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_signal,
`ifdef JUMP_REGULARIZER_STATUS_EN
    output logic o_inhibit,
`endif
    output logic o_signal
);

    // DEBOUNCE_TIME of 0 behaves exactly like 1: accept on first mismatch.
    localparam int DB_EFF = (DEBOUNCE_TIME < 1) ? 1 : DEBOUNCE_TIME;
    localparam int DC_W   = cnt_width(DEBOUNCE_TIME);
    localparam int HC_W   = cnt_width(DELAY);

    // The debounce counter never exceeds DB_EFF-1, so equality is enough
    // to detect the final counting edge.
    localparam logic [DC_W-1:0] c_DC_LAST   = DC_W'(DB_EFF - 1);
    localparam logic [HC_W-1:0] c_HOLD_LOAD = HC_W'(DELAY);

    logic            r_sample;
    logic            r_out;
    logic [DC_W-1:0] r_dc;
    logic [HC_W-1:0] r_hc;

    logic            w_out_nxt;
    logic [DC_W-1:0] w_dc_nxt;
    logic [HC_W-1:0] w_hc_nxt;

    always_comb begin
        w_out_nxt = r_out;
        w_dc_nxt  = r_dc;
        w_hc_nxt  = r_hc;
        if (r_hc != '0) begin
            // Hold: count down, ignore the input entirely.
            w_hc_nxt = r_hc - HC_W'(1);
            w_dc_nxt = '0;
        end else if (r_sample == r_out) begin
            w_dc_nxt = '0;
        end else if (r_dc == c_DC_LAST) begin
            // Mismatch has persisted long enough: accept and start the hold.
            w_out_nxt = ~r_out;
            w_dc_nxt  = '0;
            w_hc_nxt  = c_HOLD_LOAD;
        end else begin
            w_dc_nxt = r_dc + DC_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sample <= REG_RESET_LEVEL;
            r_out    <= REG_RESET_LEVEL;
            r_dc     <= '0;
            r_hc     <= '0;
        end else begin
            r_sample <= i_signal;
            r_out    <= w_out_nxt;
            r_dc     <= w_dc_nxt;
            r_hc     <= w_hc_nxt;
        end
    end

    assign o_signal = r_out;

`ifdef JUMP_REGULARIZER_STATUS_EN
    assign o_inhibit = (r_hc != '0);
`endif

endmodule
`default_nettype wire

// File: rtl/jump_regularizer.sv
`default_nettype none
// ============================================================================
// Module      : jump_regularizer
// Description : N independent channels of switching-decision regularization
//               (debounce followed by a minimum dwell time). Each bit is
//               handled by its own jump_regularizer_channel instance.
// Ports       : i_clk     - system clock, rising edge
//               i_reset   - asynchronous reset, active low
//               i_signal  - [N-1:0] raw switching requests
//               o_signal  - [N-1:0] regularized switching variables
//               o_inhibit - [N-1:0] per-channel hold status, present only
//                           when JUMP_REGULARIZER_STATUS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module jump_regularizer
    import jump_regularizer_pkg::*;
#(
    parameter int DEBOUNCE_TIME = DEFAULT_DEBOUNCE,
    parameter int DELAY         = DEFAULT_DELAY,
    parameter int N             = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_signal,
`ifdef JUMP_REGULARIZER_STATUS_EN
    output logic [N-1:0] o_inhibit,
`endif
    output logic [N-1:0] o_signal
);

    for (genvar k = 0; k < N; k++) begin : g_ch
        jump_regularizer_channel #(
            .DEBOUNCE_TIME (DEBOUNCE_TIME),
            .DELAY         (DELAY)
        ) u_channel (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_signal  (i_signal[k]),
`ifdef JUMP_REGULARIZER_STATUS_EN
            .o_inhibit (o_inhibit[k]),
`endif
            .o_signal  (o_signal[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_jump_regularizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_regularizer
// Description : Self-checking bench. Instance A (N=2, 5/200) is driven by a
//               vector table and hand sequences; instances B (N=3, 3/7) and
//               C (N=3, 0/0) get random inputs checked against a window-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_regularizer;
    import jump_regularizer_pkg::*;

    localparam int NR    = 3;
    localparam int RAND_EDGES = 1500;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    sig_a, out_a;
    logic [NR-1:0] sig_b, out_b, sig_c, out_c;
`ifdef JUMP_REGULARIZER_STATUS_EN
    logic [1:0]    inh_a;
    logic [NR-1:0] inh_b, inh_c;
`endif

    int checks   = 0;
    int failures = 0;

    initial forever #(CLK_PERIOD_NS / 2) clk = ~clk;

    jump_regularizer #(.DEBOUNCE_TIME(5), .DELAY(200), .N(2)) u_dut_a (
        .i_clk(clk), .i_reset(reset_n), .i_signal(sig_a),
`ifdef JUMP_REGULARIZER_STATUS_EN
        .o_inhibit(inh_a),
`endif
        .o_signal(out_a));

    jump_regularizer #(.DEBOUNCE_TIME(3), .DELAY(7), .N(NR)) u_dut_b (
        .i_clk(clk), .i_reset(reset_n), .i_signal(sig_b),
`ifdef JUMP_REGULARIZER_STATUS_EN
        .o_inhibit(inh_b),
`endif
        .o_signal(out_b));

    jump_regularizer #(.DEBOUNCE_TIME(0), .DELAY(0), .N(NR)) u_dut_c (
        .i_clk(clk), .i_reset(reset_n), .i_signal(sig_c),
`ifdef JUMP_REGULARIZER_STATUS_EN
        .o_inhibit(inh_c),
`endif
        .o_signal(out_c));

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model for the random phase ----------------
    // hist[x][t] is the input level captured at edge t (hist[x][0] = reset).
    // A channel toggles at edge t when the DB samples hist[t-DB..t-1] all
    // differ from the output and every counting edge t-DB+1..t lies after the
    // previous toggle's hold window.
    logic [NR-1:0] hist   [2][0:RAND_EDGES];
    int            last_t [2][NR];
    logic [NR-1:0] mo     [2];

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            hist[x][0] = '1;
            mo[x]      = '1;
            for (int k = 0; k < NR; k++) last_t[x][k] = -1000000;
        end
    endtask

    task automatic model_edge(input int x, input int t, input int db_raw, input int dly);
        int db;
        bit ok;
        db = (db_raw < 1) ? 1 : db_raw;
        for (int k = 0; k < NR; k++) begin
            if (t - db >= 0 && t - db >= last_t[x][k] + dly) begin
                ok = 1'b1;
                for (int j = 1; j <= db; j++)
                    if (hist[x][t-j][k] == mo[x][k]) ok = 1'b0;
                if (ok) begin
                    mo[x][k]     = ~mo[x][k];
                    last_t[x][k] = t;
                end
            end
        end
    endtask

    function automatic logic [NR-1:0] model_inh(input int x, input int t, input int dly);
        logic [NR-1:0] r;
        for (int k = 0; k < NR; k++) r[k] = (t - last_t[x][k] < dly);
        return r;
    endfunction

    // ---------------- directed vector table for instance A ----------------
    typedef struct {
        int         len;      // edges to apply this input for
        logic [1:0] in;
        logic [1:0] exp_o;    // expected o_signal after the last edge
        logic [1:0] exp_inh;  // expected o_inhibit after the last edge
        bit         every;    // also check exp_o after every edge
    } vec_t;

    localparam int NVEC = 12;
    vec_t tbl [NVEC];

    initial begin
        tbl[0]  = '{20,  2'b11, 2'b11, 2'b00, 1'b1}; // idle, no movement
        tbl[1]  = '{4,   2'b10, 2'b11, 2'b00, 1'b1}; // 4-edge glitch on ch0
        tbl[2]  = '{10,  2'b11, 2'b11, 2'b00, 1'b1}; // glitch rejected
        tbl[3]  = '{5,   2'b10, 2'b11, 2'b00, 1'b1}; // 5-edge pulse captured
        tbl[4]  = '{1,   2'b11, 2'b10, 2'b01, 1'b0}; // toggle at T, input back
        tbl[5]  = '{199, 2'b11, 2'b10, 2'b01, 1'b1}; // held through T+199
        tbl[6]  = '{1,   2'b11, 2'b10, 2'b00, 1'b0}; // T+200: hold just ended
        tbl[7]  = '{4,   2'b11, 2'b10, 2'b00, 1'b1}; // debouncing T+201..T+204
        tbl[8]  = '{1,   2'b11, 2'b11, 2'b01, 1'b0}; // toggles back at T+205
        tbl[9]  = '{5,   2'b01, 2'b11, 2'b01, 1'b1}; // ch1 step, ch0 in hold
        tbl[10] = '{1,   2'b01, 2'b01, 2'b11, 1'b0}; // ch1 toggles only
        tbl[11] = '{50,  2'b01, 2'b01, 2'b11, 1'b1}; // both held

        reset_n = 1'b1;
        sig_a   = 2'b00;
        sig_b   = '1;
        sig_c   = '1;

        // Async reset with no clock edge in between.
        #1 reset_n = 1'b0;
        #1;
        check("reset_a", {2'b00, out_a}, 4'b0011);
        check("reset_b", {1'b0, out_b}, 4'b0111);
        check("reset_c", {1'b0, out_c}, 4'b0111);
`ifdef JUMP_REGULARIZER_STATUS_EN
        check("reset_inh_a", {2'b00, inh_a}, 4'b0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        sig_a   = 2'b11;

        for (int i = 0; i < NVEC; i++) begin
            sig_a = tbl[i].in;
            for (int j = 0; j < tbl[i].len; j++) begin
                tick();
                if (tbl[i].every && j != tbl[i].len - 1)
                    check($sformatf("vec%0d_edge%0d", i, j), {2'b00, out_a}, {2'b00, tbl[i].exp_o});
            end
            check($sformatf("vec%0d_o", i), {2'b00, out_a}, {2'b00, tbl[i].exp_o});
`ifdef JUMP_REGULARIZER_STATUS_EN
            check($sformatf("vec%0d_inh", i), {2'b00, inh_a}, {2'b00, tbl[i].exp_inh});
`endif
        end

        // Reset in the middle of both holds: outputs return to 1 at once.
        #2 reset_n = 1'b0;
        #1;
        check("midhold_reset_o", {2'b00, out_a}, 4'b0011);
`ifdef JUMP_REGULARIZER_STATUS_EN
        check("midhold_reset_inh", {2'b00, inh_a}, 4'b0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        // ch1 input still 0: fresh debounce, no leftover hold.
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("post_reset_edge%0d", j), {2'b00, out_a}, 4'b0011);
        end
        tick();
        check("post_reset_toggle", {2'b00, out_a}, 4'b0001);
`ifdef JUMP_REGULARIZER_STATUS_EN
        check("post_reset_inh", {2'b00, inh_a}, 4'b0010);
`endif

        // ---------------- randomized phase on B and C ----------------
        sig_b = '1;
        sig_c = '1;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int t = 1; t <= RAND_EDGES; t++) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 4) == 0) sig_b[k] = ~sig_b[k];
                if ($urandom_range(0, 2) == 0) sig_c[k] = ~sig_c[k];
            end
            tick();
            model_edge(0, t, 3, 7);
            model_edge(1, t, 0, 0);
            hist[0][t] = sig_b;
            hist[1][t] = sig_c;
            check($sformatf("rndB_o_t%0d", t), {1'b0, out_b}, {1'b0, mo[0]});
            check($sformatf("rndC_o_t%0d", t), {1'b0, out_c}, {1'b0, mo[1]});
`ifdef JUMP_REGULARIZER_STATUS_EN
            check($sformatf("rndB_inh_t%0d", t), {1'b0, inh_b}, {1'b0, model_inh(0, t, 7)});
            check($sformatf("rndC_inh_t%0d", t), {1'b0, inh_c}, {1'b0, model_inh(1, t, 0)});
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
